// File: rtl/stage_sequencer.sv
// stage_sequencer: four-stage fetch/decode/execute/memory sequencer owning pc, ir and immediate decode.
module stage_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [31:0] imem_read_data,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_read_enable,
  output logic [31:0] pc,
  output logic [1:0]  stage,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [2:0]  funct3,
  output logic [31:0] immediate,
  output logic [31:0] instr_count,
  output logic        halted,
  output logic [1:0]  halt_cause
);
  logic [31:0] ir, ir_n, pc_n, imm_n, cnt_n, imm_dec;
  logic [1:0]  stage_n, cause_n;
  logic        halted_n, legal, adv;
  assign adv   = run && !halted;
  assign legal = opcode inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
  always_comb begin
    imm_dec = (opcode == 7'b0010011 || opcode == 7'b0000011 || opcode == 7'b1100111) ? {{20{ir[31]}}, ir[31:20]} :
              (opcode == 7'b0100011) ? {{20{ir[31]}}, ir[31:25], ir[11:7]} :
              (opcode == 7'b1100011) ? {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0} :
              (opcode == 7'b0110111 || opcode == 7'b0010111) ? {ir[31:12], 12'b0} :
              (opcode == 7'b1101111) ? {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0} :
              32'h0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage       <= 2'd0;
      pc          <= RESET_PC;
      ir          <= 32'h0;
      immediate   <= 32'h0;
      instr_count <= 32'h0;
      halted      <= 1'b0;
      halt_cause  <= 2'b00;
    end else begin
      stage       <= stage_n;
      pc          <= pc_n;
      ir          <= ir_n;
      immediate   <= imm_n;
      instr_count <= cnt_n;
      halted      <= halted_n;
      halt_cause  <= cause_n;
    end
  end
  // Both halt paths return the stage to FETCH so a halted core idles in stage 0.
  always_comb begin
    stage_n  = stage;
    pc_n     = pc;
    ir_n     = ir;
    imm_n    = immediate;
    cnt_n    = instr_count;
    halted_n = halted;
    cause_n  = halt_cause;
    if (adv) begin
      case (stage)
        2'd0: begin
          ir_n    = imem_read_data;
          stage_n = 2'd1;
        end
        2'd1: begin
          imm_n    = legal ? imm_dec : immediate;
          stage_n  = legal ? 2'd2 : 2'd0;
          halted_n = !legal;
          cause_n  = legal ? halt_cause : 2'b01;
        end
        2'd2: stage_n = 2'd3;
        default: begin
          stage_n = 2'd0;
          if (branch_taken && branch_target[1:0] != 2'b00) begin
            halted_n = 1'b1;
            cause_n  = 2'b10;
          end else begin
            pc_n  = branch_taken ? branch_target : pc + 32'd4;
            cnt_n = instr_count + 32'd1;
          end
        end
      endcase
    end
  end
  assign imem_read_enable = (stage == 2'd0) && !halted && run;
  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct3 = ir[14:12];
endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Front-end controller for the multi-cycle RV32I core. It steps the four-stage cycle FETCH → DECODE → EXECUTE → MEMORY and owns the program counter and instruction register. It decodes register fields and generates the sign-extended immediate. It drives the `stage`, `opcode` and `immediate` buses consumed by the execute/address and load/store stages downstream.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `run`  in  1  advance enable; 0 freezes all state.
- `imem_read_data`  in  32  instruction word at `pc`, valid combinationally during stage 0.
- `branch_taken`  in  1  sampled at end of stage 3; redirect request.
- `branch_target`  in  32  sampled with `branch_taken`.
- `imem_read_enable`  out  1  high only in stage 0, not halted, `run`=1.
- `pc`  out  32  current instruction address.
- `stage`  out  2  0=FETCH, 1=DECODE, 2=EXECUTE, 3=MEMORY.
- `opcode`  out  7  `ir[6:0]`.
- `rd`, `rs1`, `rs2`  out  5 each  `ir[11:7]`, `ir[19:15]`, `ir[24:20]`.
- `funct3`  out  3  `ir[14:12]`.
- `immediate`  out  32  decoded immediate, registered.
- `instr_count`  out  32  retired-instruction counter.
- `halted`  out  1  sticky halt flag.
- `halt_cause`  out  2  01=illegal opcode, 10=misaligned target, 00=none.

## Operation
- Reset (async assert): `stage`=0, `pc`=`RESET_PC`, `ir`=0 (so `opcode`/fields=0), `immediate`=0, `instr_count`=0, `halted`=0, `halt_cause`=00. The block exits reset on the first edge after `rst_n` rises.
- The stage counter is 2 bits and advances 0→1→2→3→0 on each edge with `run`=1 and `halted`=0. Otherwise every register holds.
- End of stage 0: `ir` ← `imem_read_data`.
- End of stage 1: the opcode is checked against the legal set {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111}.
  - Legal: `immediate` is loaded per format and stage goes to 2.
  - Illegal: `halted`←1, `halt_cause`←01, stage←0, `pc` unchanged, `immediate` unchanged.
- Immediate formats (all results 32-bit, sign bit is `ir[31]`):
  - I (0010011, 0000011, 1100111): sext(`ir[31:20]`).
  - S (0100011): sext({`ir[31:25]`,`ir[11:7]`}).
  - B (1100011): sext({`ir[31]`,`ir[7]`,`ir[30:25]`,`ir[11:8]`,0}).
  - U (0110111, 0010111): {`ir[31:12]`, 12'b0}.
  - J (1101111): sext({`ir[31]`,`ir[19:12]`,`ir[20]`,`ir[30:21]`,0}).
  - R: 0.
- End of stage 3 (retire):
  - If `branch_taken`=1 and `branch_target[1:0]`≠00: `halted`←1, `halt_cause`←10, `pc` unchanged, no retire count.
  - Otherwise `pc` ← `branch_taken` ? `branch_target` : `pc`+4, and `instr_count` increments.
- `pc`+4 and `instr_count` wrap modulo 2^32 with no flag.
- Halt is sticky and leaves only via reset. While halted: `stage`=0, `imem_read_enable`=0, `ir`/`immediate` hold their last values.

## Timing
- `stage`, `pc`, `ir`, `immediate` and `instr_count` are registered. `imem_read_enable` and the field outputs are combinational from registers only, with no input-to-output path.
- An instruction takes 4 cycles with `run` held high. `immediate` is valid during stages 2 and 3 and stable until the next end of stage 1. `opcode`/fields are valid during stages 1–3.
- `run`=0 for N cycles stretches the current stage by exactly N cycles. Outputs are unchanged during the stall.
- If `branch_taken` is asserted outside the end-of-stage-3 edge, it is ignored.
- Reset asserted mid-instruction (any stage) takes effect immediately. The in-flight instruction is discarded and not counted.

## Test plan
- Reset check: assert `rst_n`=0 mid-cycle. All outputs reach reset values without a clock edge; after release, `pc`=0, `stage`=0, `imem_read_enable`=1.
- Load `lw x5,8(x2)`: drive `imem_read_data`=32'h00812283 in stage 0.
  - Stages 2–3: `opcode`=0000011, `rs1`=2, `rd`=5, `funct3`=010, `immediate`=8.
  - After stage 3: `pc`=4, `instr_count`=1.
- Negative immediate, then taken branch:
  - 32'hFFC02083 gives `immediate`=32'hFFFFFFFC.
  - A following instruction with `branch_taken`=1 and target 32'h100 at end of stage 3 gives `pc`=32'h100.
- Illegal opcode: drive 32'h00000000. At end of stage 1: `halted`=1, `halt_cause`=01, `stage`=0, `pc` unchanged. Further clocks change nothing.
- Misaligned redirect: `branch_target`=32'h102, `branch_taken`=1 at stage 3 gives `halted`=1, `halt_cause`=10, `pc` unchanged, `instr_count` not incremented.
- Stall and reset mid-op:
  - `run`=0 for 3 cycles in stage 2 holds `stage`=2 for 4 cycles total.
  - Then `rst_n`=0 gives `stage`=0, `pc`=`RESET_PC`, `instr_count`=0.
